mux_scan_sequencer: RTL
=======================

Name: mux_scan_sequencer

Overview:
- Sequencer that drives the 2-bit select of the team's 4:1 single-bit multiplexer and consumes its output.
- Steps the select through channels 0..3, dwelling DWELL cycles on each, and samples the mux output on the last dwell cycle.
- Packs the four samples into a 4-bit frame and presents it downstream with a valid/ready handshake.
- Supports single-shot and continuous scanning.

Parameters:
- DWELL, 4: clock cycles spent on each channel, including the sample cycle; legal range 1..255.
- CNT_W, 8: width of the dwell counter; must satisfy 2^CNT_W > DWELL-1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a scan; sampled only in IDLE.
- continuous  input  1  sampled with start; 1 restarts a scan automatically after each accepted frame.
- stop  input  1  ends continuous mode; the frame in flight completes normally.
- mux_out  input  1  output of the 4:1 mux under control.
- sel  output  2  mux select; 2'b00 selects channel a ... 2'b11 selects channel d.
- busy  output  1  high whenever not in IDLE.
- frame  output  4  captured samples; bit i is the channel-i sample.
- frame_valid  output  1  frame is available.
- frame_ready  input  1  downstream accepts frame.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, sel=0, dwell counter=0, sample buffer=0, frame=0, frame_valid=0, busy=0, continuous flag=0.
- FSM states: IDLE, SCAN, PRESENT.
- IDLE:
  - sel held at 0.
  - start=1 → SCAN, sel=0, cnt=0, continuous flag latched from continuous.
- SCAN:
  - cnt increments each cycle.
  - When cnt==DWELL-1, mux_out is written to buf[sel] and cnt returns to 0.
  - If sel<3, sel increments.
  - If sel==3, frame is loaded from buf with bit 3 taken from mux_out in the same cycle, frame_valid=1, state → PRESENT, sel stays at 3.
- PRESENT:
  - frame and frame_valid hold stable until frame_valid && frame_ready.
  - On acceptance, frame_valid=0.
  - If the continuous flag is set and stop has not been seen: → SCAN with sel=0, cnt=0.
  - Otherwise: → IDLE, sel=0.
- Latency: frame_valid rises exactly 4*DWELL cycles after the edge that samples start.
  - In continuous mode with frame_ready tied high, consecutive frames are 4*DWELL+1 cycles apart; the PRESENT cycle is the single bubble.
- frame_ready arriving early (while frame_valid=0) is ignored; frame_ready asserted in the same cycle frame_valid first rises is accepted on the following edge.
- start while busy is ignored.
- stop:
  - Pulse in any non-IDLE state clears the continuous flag.
  - stop in IDLE has no effect.
  - stop and start in the same IDLE cycle: start wins, continuous flag=0.
- sel changes only at sample edges, so the mux sees each channel for a full DWELL cycles.
- DWELL=1: sel advances every cycle.
- Reset deasserted mid-scan: next start restarts from channel 0.

Optional Feature:
- Macro: MUX_SCAN_PARITY_EN.
- Defined: adds output frame_par (1 bit), registered alongside frame, equal to the XOR of the four frame bits; reset value 0; it obeys the same hold rule as frame.
- Undefined: port absent, no parity logic; all other behaviour identical.

Decomposition:
- Shared package mux_scan_pkg: state enum (IDLE=2'd0, SCAN=2'd1, PRESENT=2'd2), NUM_CH=4, SEL_W=2.
- One natural sub-module, dwell_counter: CNT_W-bit counter with clear and enable inputs, plus a terminal-count output asserted at DWELL-1.
- FSM, select register and sample buffer stay in the top module.

Test Plan:
- Single scan, DWELL=4:
  - Stimulus: mux driven by a=1, b=0, c=1, d=1; pulse start at cycle 0; frame_ready=1.
  - Required: sel sequence 0,1,2,3 with 4 cycles each; frame_valid at cycle 16; frame=4'b1101; busy drops the cycle after acceptance.
- Backpressure:
  - Stimulus: frame_ready=0 for 10 cycles after frame_valid rises; change mux inputs during the stall.
  - Required: frame and frame_valid stay constant; accepted the edge after frame_ready rises; single-shot returns to IDLE.
- Continuous with stop:
  - Stimulus: start with continuous=1, DWELL=2, frame_ready=1; pulse stop during the second scan.
  - Required: frames at cycles 8 and 17; no third scan; IDLE after the second handshake.
- Boundary DWELL=1:
  - Stimulus: mux inputs 1,0,0,1.
  - Required: sel changes every cycle; frame=4'b1001 valid 4 cycles after start.
- Asynchronous reset mid-scan:
  - Stimulus: assert rst_n low between clock edges while sel=2.
  - Required: sel, frame, frame_valid and busy go to 0 immediately; a fresh start restarts from channel 0.
- Parity, with MUX_SCAN_PARITY_EN defined:
  - Stimulus: scan producing frame=4'b0111.
  - Required: frame_par=1; for frame=4'b0110, frame_par=0.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux scan sequencer.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN    = 2'd1,
        PRESENT = 2'd2
    } state_e;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CH - 1);

endpackage

// File: rtl/mux_scan_sequencer_dwell_counter.sv
// Dwell counter: counts while enabled, wraps to zero at the terminal count
// (DWELL-1), and is held at zero while clr is asserted.
module dwell_counter #(
    parameter int unsigned DWELL = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc = (cnt_q == TC_VAL);

    always_comb begin
        cnt_d = cnt_q;
        if (clr || (en && tc)) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps a 4:1 mux select through all channels, samples each after DWELL
// cycles and presents the packed frame over valid/ready.
// Optional parity output frame_par is enabled by MUX_SCAN_PARITY_EN.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int unsigned DWELL = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                continuous,
    input  logic                stop,
    input  logic                mux_out,
    output logic [SEL_W-1:0]    sel,
    output logic                busy,
    output logic [NUM_CH-1:0]   frame,
`ifdef MUX_SCAN_PARITY_EN
    output logic                frame_par,
`endif
    output logic                frame_valid,
    input  logic                frame_ready
);

    state_e              state_q;
    logic [SEL_W-1:0]    sel_q;
    logic [NUM_CH-2:0]   samp_q;
    logic [NUM_CH-1:0]   frame_q;
    logic                frame_valid_q;
    logic                cont_q;
    logic                tc;
`ifdef MUX_SCAN_PARITY_EN
    logic                frame_par_q;
`endif

    // Counter sits at zero outside SCAN, so every scan starts a fresh dwell.
    dwell_counter #(
        .DWELL (DWELL),
        .CNT_W (CNT_W)
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_q != SCAN),
        .en    (state_q == SCAN),
        .tc    (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            sel_q         <= '0;
            samp_q        <= '0;
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
            cont_q        <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
            frame_par_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    sel_q <= '0;
                    if (start) begin
                        state_q <= SCAN;
                        cont_q  <= continuous & ~stop;
                    end
                end
                SCAN: begin
                    if (stop) begin
                        cont_q <= 1'b0;
                    end
                    if (tc) begin
                        if (sel_q == LAST_SEL) begin
                            // Last channel bypasses the buffer and lands in the frame directly.
                            frame_q       <= {mux_out, samp_q};
                            frame_valid_q <= 1'b1;
                            state_q       <= PRESENT;
`ifdef MUX_SCAN_PARITY_EN
                            frame_par_q   <= ^{mux_out, samp_q};
`endif
                        end else begin
                            samp_q[sel_q] <= mux_out;
                            sel_q         <= sel_q + 1'b1;
                        end
                    end
                end
                PRESENT: begin
                    if (stop) begin
                        cont_q <= 1'b0;
                    end
                    if (frame_valid_q && frame_ready) begin
                        frame_valid_q <= 1'b0;
                        sel_q         <= '0;
                        state_q       <= (cont_q && !stop) ? SCAN : IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    sel_q   <= '0;
                end
            endcase
        end
    end

    assign sel         = sel_q;
    assign busy        = (state_q != IDLE);
    assign frame       = frame_q;
    assign frame_valid = frame_valid_q;
`ifdef MUX_SCAN_PARITY_EN
    assign frame_par   = frame_par_q;
`endif

endmodule
